drop_scheduler: RTL and testbench
=================================

// Module: drop_scheduler
// PURPOSE
//  Sequences the falling-piece datapath for the two-player game. Arbitrates drop requests from
//  P0/P1, then steps the granted player's piece down one STEP per gravity tick. Each step is an
//  erase/move/draw sequence with a plot handshake to the VGA drawer, ending when the piece lands.
//  Sits between the player input logic and the vga plot/colour mux.
// PARAMETERS
//  STEP      10   rows moved per tick
//  TOP_Y     0    start row of a new drop
//  BOTTOM_Y  54   landing row (7'b0110110)
//  X_P0      0    column of player 0 piece
//  X_P1      118  column of player 1 piece (8'b01110110)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high reset
//  req        in   2  drop request per player, level; bit i = player i
//  clr_landed in   2  1-cycle pulse, clears landed[i]
//  tick       in   1  1-cycle gravity pulse
//  plot_done  in   1  drawer has finished the current plot
//  plot       out  1  plot request to drawer, held until plot_done
//  erase      out  1  1 = draw background colour, 0 = player colour (valid while plot=1)
//  x          out  8  column of piece being drawn
//  y          out  7  row of piece being drawn
//  grant      out  2  one-hot owner of datapath, 0 when idle
//  busy       out  1  state != IDLE
//  landed     out  2  sticky per-player "at bottom" flag
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; last_grant = P1, so P0 wins the first tie. Reset acts
//   immediately mid-operation: plot drops at once and no cycle completes.
//  Eligible[i] = req[i] & ~landed[i]. Registered outputs change on the clk edge after the decision.
//  IDLE: if any eligible player -> grant that player. Round-robin on a tie: grant != last_grant.
//   Latch x = X_Pi and y = TOP_Y -> DRAW.
//  DRAW: plot=1, erase=0. On plot_done -> plot=0 next cycle -> HOLD.
//  HOLD: wait for tick. On tick with y==BOTTOM_Y: landed[g]=1, last_grant=g, grant=0 -> IDLE.
//   On tick otherwise -> ERASE.
//  ERASE: plot=1, erase=1 at current x,y. On plot_done -> MOVE.
//  MOVE (1 cycle): y = min(y+STEP, BOTTOM_Y). Sum is formed 8 bits wide, so no 7-bit wrap -> DRAW.
//  Handshake: plot high until plot_done is sampled high; completion takes 1 cycle minimum.
//   plot_done with plot=0 is ignored. x/y/erase stay stable while plot=1.
//  tick outside HOLD is dropped, not queued. req deassert mid-drop does not abort; the drop completes.
//  clr_landed[i] and landing of player i in the same cycle: set wins (landed[i]=1).
//  A player with landed=1 is never granted until cleared.
// CONFIGURATION
//  DROP_COUNT_EN defined: extra output land_cnt[15:0] = {P1[7:0],P0[7:0]}.
//   Each byte increments on that player's landing, wraps 255->0, is reset to 0, and is
//   unaffected by clr_landed.
//  Undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Package drop_pkg: state enum (IDLE,DRAW,HOLD,ERASE,MOVE), player_t (1-bit index),
//   STEP/TOP_Y/BOTTOM_Y/X_P0/X_P1 defaults, XW=8, YW=7.
//  Sub-module rr_arbiter2: 2-way round-robin arbiter (eligible, last_grant -> one-hot grant).
//  FSM, y stepper and landed flags stay in drop_scheduler.
// TESTING
//  1 reset; req=01; plot_done 1 cycle after each plot -> grant=01, x=0. Drawn y = 0,10,20,30,40,50,54.
//    7th tick sets landed=01 and grant=00.
//  2 req=11 from reset -> P0 drop runs to landing, then grant=10, x=118, y=0. P1 lands -> landed=11.
//  3 landed=01, req=01 held -> no grant. clr_landed=01 pulse -> grant=01 next decision.
//  4 plot_done delayed 5 cycles in ERASE; tick pulsed there -> plot/x/y/erase stable 5 cycles.
//    The tick is dropped: y advances only on a later HOLD tick.
//  5 reset asserted during ERASE -> plot, erase, grant, busy, x, y, landed all 0 immediately.
//    req=10 after release -> P1 granted.
//  6 DROP_COUNT_EN: three P0 landings with clr between -> land_cnt=16'h0003. Clr same cycle as landing -> landed stays 1.

Source files
------------

// File: rtl/drop_scheduler_pkg.sv
// Shared types and default geometry for the falling-piece scheduler.
package drop_pkg;
  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int STEP     = 10;
  localparam int TOP_Y    = 0;
  localparam int BOTTOM_Y = 54;
  localparam int X_P0     = 0;
  localparam int X_P1     = 118;

  typedef enum logic [2:0] {IDLE, DRAW, HOLD, ERASE, MOVE} state_e;
  typedef logic player_t;

  function automatic logic [1:0] player_onehot(player_t p);
    return p ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/drop_scheduler_if.sv
// Player-input / plot-drawer bundle of the drop scheduler.
// DROP_COUNT_EN adds the per-player landing counter output land_cnt.
interface drop_scheduler_if;
  import drop_pkg::*;
  logic [1:0]    req;
  logic [1:0]    clr_landed;
  logic          tick;
  logic          plot_done;
  logic          plot;
  logic          erase;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    grant;
  logic          busy;
  logic [1:0]    landed;
`ifdef DROP_COUNT_EN
  logic [15:0]   land_cnt;
`endif

  modport master (
    input  req, clr_landed, tick, plot_done,
    output plot, erase, x, y, grant, busy, landed
`ifdef DROP_COUNT_EN
    , output land_cnt
`endif
  );

  modport slave (
    output req, clr_landed, tick, plot_done,
    input  plot, erase, x, y, grant, busy, landed
`ifdef DROP_COUNT_EN
    , input land_cnt
`endif
  );
endinterface

// File: rtl/drop_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: a tie goes to the player that did not own the last drop.
module rr_arbiter2
  import drop_pkg::*;
(
  input  logic [1:0] eligible_i,
  input  player_t    last_grant_i,
  output logic [1:0] grant_o
);
  always_comb begin
    grant_o = 2'b00;
    case (eligible_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = player_onehot(~last_grant_i);
      default: grant_o = 2'b00;
    endcase
  end
endmodule

// File: rtl/drop_scheduler.sv
// Arbitrates P0/P1 drop requests and walks the granted piece down with erase/move/draw plots.
// DROP_COUNT_EN adds land_cnt = {P1 landings, P0 landings}, 8-bit wrapping counters.
module drop_scheduler #(
  parameter int STEP     = drop_pkg::STEP,
  parameter int TOP_Y    = drop_pkg::TOP_Y,
  parameter int BOTTOM_Y = drop_pkg::BOTTOM_Y,
  parameter int X_P0     = drop_pkg::X_P0,
  parameter int X_P1     = drop_pkg::X_P1
) (
  input  logic              clk,
  input  logic              reset,
  drop_scheduler_if.master  bus
);
  import drop_pkg::*;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    landed_q, landed_d;
  player_t       last_q, last_d;
  logic [1:0]    eligible;
  logic [1:0]    arb_grant;
  logic          land_now;
  logic [YW:0]   y_sum;

  assign eligible = bus.req & ~landed_q;
  // One bit wider than y so a step past the bottom clamps instead of wrapping.
  assign y_sum    = {1'b0, y_q} + (YW+1)'(STEP);

  rr_arbiter2 u_arb (
    .eligible_i   (eligible),
    .last_grant_i (last_q),
    .grant_o      (arb_grant)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    grant_d  = grant_q;
    last_d   = last_q;
    land_now = 1'b0;
    case (state_q)
      IDLE: if (arb_grant != 2'b00) begin
        grant_d = arb_grant;
        x_d     = arb_grant[1] ? XW'(X_P1) : XW'(X_P0);
        y_d     = YW'(TOP_Y);
        state_d = DRAW;
      end
      DRAW:  if (bus.plot_done) state_d = HOLD;
      HOLD: if (bus.tick) begin
        if (y_q == YW'(BOTTOM_Y)) begin
          land_now = 1'b1;
          last_d   = grant_q[1];
          grant_d  = 2'b00;
          state_d  = IDLE;
        end else begin
          state_d  = ERASE;
        end
      end
      ERASE: if (bus.plot_done) state_d = MOVE;
      MOVE: begin
        y_d     = (y_sum > (YW+1)'(BOTTOM_Y)) ? YW'(BOTTOM_Y) : y_sum[YW-1:0];
        state_d = DRAW;
      end
      default: state_d = IDLE;
    endcase
    // A landing in the same cycle as its clear keeps the flag set.
    landed_d = (landed_q & ~bus.clr_landed) | (land_now ? grant_q : 2'b00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      grant_q  <= '0;
      landed_q <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      grant_q  <= grant_d;
      landed_q <= landed_d;
      last_q   <= last_d;
    end
  end

  assign bus.plot   = (state_q == DRAW) || (state_q == ERASE);
  assign bus.erase  = (state_q == ERASE);
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.grant  = grant_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.landed = landed_q;

`ifdef DROP_COUNT_EN
  logic [7:0] cnt_w [2];
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [7:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                       cnt_q <= '0;
      else if (land_now && grant_q[gi]) cnt_q <= cnt_q + 8'd1;
    end
    assign cnt_w[gi] = cnt_q;
  end
  assign bus.land_cnt = {cnt_w[1], cnt_w[0]};
`endif
endmodule

// File: tb/tb_drop_scheduler.sv
// Self-checking bench for drop_scheduler: directed scenarios plus randomized drops against a plot-sequence model.
module tb_drop_scheduler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  drop_scheduler_if dif();
  drop_scheduler dut (.clk(clk), .reset(reset), .bus(dif));

  typedef struct {
    logic       erase;
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] g;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  d_ev;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_delay = 1;
  int   wait_cnt = 0;
  bit   stray_en = 0;
  bit   last_was_draw = 0;
  logic [1:0] m_landed;
  int   m_last;
  int   m_cnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected plot stream of one complete drop: draw, then erase+draw per step, ending at the bottom.
  task automatic push_drop(input int p);
    ev_t e;
    int  yy;
    yy = 0;
    forever begin
      e.erase = 1'b0;
      e.x     = (p == 1) ? 8'd118 : 8'd0;
      e.y     = 7'(yy);
      e.g     = (p == 1) ? 2'b10 : 2'b01;
      exp_q.push_back(e);
      if (yy == 54) break;
      e.erase = 1'b1;
      exp_q.push_back(e);
      yy = (yy + 10 > 54) ? 54 : yy + 10;
    end
  endtask

  // Drawer model: completes each plot after done_delay cycles and checks it against the model.
  always @(negedge clk) begin
    if (dif.plot !== 1'b1) begin
      wait_cnt      = 0;
      dif.plot_done = stray_en && ($urandom_range(0, 3) == 0);
    end else if (wait_cnt >= done_delay) begin
      dif.plot_done = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_plot", 1, 0);
      end else begin
        d_ev = exp_q.pop_front();
        check("plot_erase", 32'(dif.erase), 32'(d_ev.erase));
        check("plot_x", 32'(dif.x), 32'(d_ev.x));
        check("plot_y", 32'(dif.y), 32'(d_ev.y));
        check("plot_grant", 32'(dif.grant), 32'(d_ev.g));
      end
      last_was_draw = !dif.erase;
      $display("plot erase=%0d x=%0d y=%0d grant=%b", dif.erase, dif.x, dif.y, dif.grant);
    end else begin
      wait_cnt++;
      dif.plot_done = 1'b0;
    end
  end

  task automatic model_reset();
    exp_q.delete();
    m_landed = 2'b00;
    m_last = 1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    last_was_draw = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    dif.req = 2'b00;
    dif.clr_landed = 2'b00;
    dif.tick = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_clr(input logic [1:0] c);
    dif.clr_landed = c;
    m_landed = m_landed & ~c;
    @(negedge clk);
    dif.clr_landed = 2'b00;
  endtask

  task automatic pulse_tick();
    dif.tick = 1'b1;
    @(negedge clk);
    dif.tick = 1'b0;
  endtask

  task automatic wait_hold();
    int n;
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (dif.busy && !dif.plot && last_was_draw) break;
    end
    check("hold_wait", 32'(n < 1000), 1);
  endtask

  task automatic start_drop(input logic [1:0] r, output bit granted, output int p);
    logic [1:0] elig;
    @(negedge clk);
    dif.req = r;
    elig = r & ~m_landed;
    granted = (elig != 2'b00);
    if (elig == 2'b11) p = (m_last == 1) ? 0 : 1;
    else               p = elig[1] ? 1 : 0;
    if (granted) push_drop(p);
    @(negedge clk);
    if (granted) begin
      check("start_grant", 32'(dif.grant), (p == 1) ? 2 : 1);
      check("start_busy", 32'(dif.busy), 1);
      check("start_x", 32'(dif.x), (p == 1) ? 118 : 0);
      check("start_y", 32'(dif.y), 0);
      $display("drop start req=%b grant=%b x=%0d", r, dif.grant, dif.x);
      dif.req = 2'($urandom);
    end else begin
      repeat (2) begin
        @(negedge clk);
        check("no_grant", 32'({dif.busy, dif.grant}), 0);
      end
      $display("drop refused req=%b landed=%b", r, dif.landed);
      dif.req = 2'b00;
    end
  endtask

  task automatic finish_drop(input int p, input bit clr_at_land);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      dif.clr_landed = 2'b00;
      if (!dif.busy) break;
      dif.tick = ($urandom_range(0, 2) == 0);
      if (clr_at_land && !dif.plot && last_was_draw && exp_q.size() == 0) begin
        dif.tick = 1'b1;
        dif.clr_landed = (p == 1) ? 2'b10 : 2'b01;
      end
    end
    dif.tick = 1'b0;
    dif.req = 2'b00;
    dif.clr_landed = 2'b00;
    check("land_timeout", 32'(n < 3000), 1);
    check("plots_left", 32'(exp_q.size()), 0);
    m_landed[p] = 1'b1;
    m_last = p;
    m_cnt[p] = (m_cnt[p] + 1) % 256;
    check("land_flags", 32'(dif.landed), 32'(m_landed));
    check("land_grant", 32'(dif.grant), 0);
`ifdef DROP_COUNT_EN
    check("land_cnt", 32'(dif.land_cnt), 32'({8'(m_cnt[1]), 8'(m_cnt[0])}));
`endif
    $display("drop landed player=%0d landed=%b", p, dif.landed);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    int p;
    reset = 1'b1;
    dif.req = 2'b00;
    dif.clr_landed = 2'b00;
    dif.tick = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_plot", 32'({dif.plot, dif.erase}), 0);
    check("rst_xy", 32'({dif.x, dif.y}), 0);
    check("rst_grant_busy", 32'({dif.grant, dif.busy}), 0);
    check("rst_landed", 32'(dif.landed), 0);
    reset = 1'b0;

    // P0 alone, drawer answers one cycle after each plot.
    done_delay = 1;
    start_drop(2'b01, g, p);
    if (g) finish_drop(p, 0);
    check("t1_landed", 32'(dif.landed), 1);

    // Both request: P0 first, then P1.
    do_reset();
    start_drop(2'b11, g, p);
    check("t2_first_p0", 32'(p), 0);
    if (g) finish_drop(p, 0);
    start_drop(2'b11, g, p);
    check("t2_second_p1", 32'(p), 1);
    if (g) finish_drop(p, 0);
    check("t2_landed", 32'(dif.landed), 3);

    // Landed player blocked until its flag is cleared.
    pulse_clr(2'b10);
    dif.req = 2'b01;
    repeat (3) begin
      @(negedge clk);
      check("t3_blocked", 32'({dif.busy, dif.grant}), 0);
    end
    dif.clr_landed = 2'b01;
    m_landed = m_landed & ~2'b01;
    push_drop(0);
    @(negedge clk);
    dif.clr_landed = 2'b00;
    check("t3_clr_cycle", 32'({dif.grant, dif.landed}), 0);
    @(negedge clk);
    check("t3_grant", 32'(dif.grant), 1);
    dif.req = 2'b00;
    finish_drop(0, 0);

    // Slow erase handshake with a tick inside it: outputs stable, tick dropped.
    pulse_clr(2'b11);
    done_delay = 0;
    start_drop(2'b01, g, p);
    wait_hold();
    done_delay = 5;
    pulse_tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_stable", 32'({dif.plot, dif.erase, dif.x, dif.y}), 32'({2'b11, 8'd0, 7'd0}));
      dif.tick = (i == 2);
      @(negedge clk);
    end
    dif.tick = 1'b0;
    wait_hold();
    repeat (6) begin
      @(negedge clk);
      check("t4_tick_dropped", 32'({dif.busy, dif.plot, dif.y}), 32'({2'b10, 7'd10}));
    end
    done_delay = 1;
    finish_drop(0, 0);

    // Reset during erase clears everything at once.
    pulse_clr(2'b11);
    done_delay = 20;
    start_drop(2'b01, g, p);
    wait_hold();
    pulse_tick();
    check("t5_in_erase", 32'({dif.plot, dif.erase}), 3);
    reset = 1'b1;
    #1;
    check("t5_rst_plot", 32'({dif.plot, dif.erase}), 0);
    check("t5_rst_grant_busy", 32'({dif.grant, dif.busy}), 0);
    check("t5_rst_xy", 32'({dif.x, dif.y}), 0);
    check("t5_rst_landed", 32'(dif.landed), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    done_delay = 1;
    start_drop(2'b10, g, p);
    check("t5_p1", 32'(p), 1);
    if (g) finish_drop(p, 0);

    // Three P0 landings, the last cleared in the same cycle it lands.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pulse_clr(2'b01);
      start_drop(2'b01, g, p);
      if (g) finish_drop(p, k == 2);
    end
    check("t6_set_wins", 32'(dif.landed), 1);
`ifdef DROP_COUNT_EN
    check("t6_cnt", 32'(dif.land_cnt), 32'h0003);
`endif

    // Randomized drops with stray plot_done and random clears.
    stray_en = 1;
    for (int k = 0; k < 12; k++) begin
      done_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        pulse_clr(2'($urandom));
      end
      start_drop(2'($urandom), g, p);
      if (g) finish_drop(p, $urandom_range(0, 3) == 0);
    end
    stray_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
